ctech_clkreq_responder: RTL

- Responder end of the four-phase clock-request handshake (clkreq/clkack) for one gated clock domain.
- Synchronizes an asynchronous request from the consuming domain and drives the enable of the downstream non-clock AND/clock-gate cell.
- Applies a wake settle delay before acknowledging.
- Holds the clock on for a programmable hysteresis window after the request drops.

---
 rtl/ctech_clkreq_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ctech_clkreq_responder.sv
// ctech_clkreq_responder
// Responder side of the four-phase clkreq/clkack handshake for one gated
// clock domain. The asynchronous request is synchronized, the clock-gate
// enable is raised first, and the acknowledge follows only after a wake
// settle delay. When the request drops, the clock is held on for a
// programmable hysteresis window before the gate is closed.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | gate closed, no request seen
// WAKE  | gate open, waiting WAKE_CYC cycles for the clock to settle
// ON    | clock running, clkack follows the synchronized request
// HOLD  | request gone, clock kept running for hyst_i+1 cycles
module ctech_clkreq_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int WAKE_CYC    = 4,
    parameter int HYST_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkreq_i,
    input  logic              force_on_i,
    input  logic [HYST_W-1:0] hyst_i,
    output logic              gate_en_o,
    output logic              clkack_o,
    output logic [1:0]        state_o
);

    // Wake counter only needs to hold WAKE_CYC-1; keep at least one bit.
    localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WCW-1:0]    WAKE_LOAD = WCW'(WAKE_CYC - 1);
    localparam logic [WCW-1:0]    WAKE_ONE  = WCW'(1);
    localparam logic [HYST_W-1:0] HYST_ONE  = HYST_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Reject illegal parameterizations at elaboration time.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (WAKE_CYC < 1) begin : g_bad_wake
            $error("WAKE_CYC must be at least 1");
        end
        if (HYST_W < 1) begin : g_bad_hyst
            $error("HYST_W must be at least 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    state_t                 state_q,    state_d;
    logic [WCW-1:0]         wake_cnt_q, wake_cnt_d;
    logic [HYST_W-1:0]      hyst_cnt_q, hyst_cnt_d;
    logic                   gate_en_q;
    logic                   clkack_q;

    // Request synchronizer: the only place clkreq_i is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clkreq_i};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Next-state and counter logic; the request wins over hysteresis expiry.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        hyst_cnt_d = hyst_cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (req_s || force_on_i) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // A withdrawn request is not acted on here; ON will see it.
                if (wake_cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    wake_cnt_d = wake_cnt_q - WAKE_ONE;
                end
            end
            ST_ON: begin
                if (!req_s) begin
                    state_d    = ST_HOLD;
                    hyst_cnt_d = hyst_i;
                end
            end
            ST_HOLD: begin
                if (req_s) begin
                    // Clock never stopped, so no wake delay is needed.
                    state_d = ST_ON;
                end else if (force_on_i) begin
                    hyst_cnt_d = hyst_i;
                end else if (hyst_cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    hyst_cnt_d = hyst_cnt_q - HYST_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // FSM registers with registered gate enable and acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= '0;
            hyst_cnt_q <= '0;
            gate_en_q  <= 1'b0;
            clkack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            hyst_cnt_q <= hyst_cnt_d;
            // Dedicated flop so the gate enable never glitches on state decode.
            gate_en_q  <= (state_d != ST_OFF);
            // Only acknowledged from ON, where gate_en is guaranteed high.
            clkack_q   <= (state_q == ST_ON) && req_s;
        end
    end

    assign gate_en_o = gate_en_q;
    assign clkack_o  = clkack_q;
    assign state_o   = state_q;

endmodule
